// File: rtl/tdc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tdc_pkg
//  Description : Shared types and default constants for the TDC coarse/fine
//                splitter: FSM state encoding, default widths and divisor.
//  Revision    : 1.0 - initial release
// ============================================================================
package tdc_pkg;

    // Default fine-unit input width, coarse output width, fine output width
    localparam int C_IN_W    = 37;
    localparam int C_Q_W     = 32;
    localparam int C_FRAC_W  = 7;
    // Fine units per coarse tick
    localparam int C_DIVISOR = 50;

    // Divider controller states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } tdc_state_t;

endpackage : tdc_pkg
`default_nettype wire

// File: rtl/tdc_div_step.sv
`default_nettype none
// ============================================================================
//  Module      : tdc_div_step
//  Description : One restoring-division step. The next dividend bit is shifted
//                into the partial remainder; if the result reaches DIVISOR,
//                DIVISOR is subtracted and the quotient bit is 1.
//  Revision    : 1.0 - initial release
// ============================================================================
module tdc_div_step
    import tdc_pkg::*;
#(
    parameter int FRAC_W  = C_FRAC_W,
    parameter int DIVISOR = C_DIVISOR
) (
    input  logic [FRAC_W:0] i_rem,
    input  logic            i_bit,
    output logic [FRAC_W:0] o_rem_next,
    output logic            o_q_bit
);

    // One bit wider than the remainder so the shifted value never wraps
    logic [FRAC_W+1:0] w_shifted;
    logic [FRAC_W+1:0] w_diff;

    assign w_shifted = {i_rem, i_bit};
    assign w_diff    = w_shifted - (FRAC_W+2)'(DIVISOR);

    // Compare-and-subtract; remainder stays below DIVISOR after every step
    always_comb begin
        o_q_bit    = 1'b0;
        o_rem_next = (FRAC_W+1)'(w_shifted);
        if (w_shifted >= (FRAC_W+2)'(DIVISOR)) begin
            o_q_bit    = 1'b1;
            o_rem_next = (FRAC_W+1)'(w_diff);
        end
    end

endmodule : tdc_div_step
`default_nettype wire

// File: rtl/tdc_split_x50.sv
`default_nettype none
// ============================================================================
//  Module      : tdc_split_x50
//  Description : Splits a fine-unit time value into coarse ticks (quotient)
//                and fine residue (remainder) by a constant DIVISOR, using a
//                bit-serial restoring divider (IN_W steps, MSB first).
//                Optional feature macro: TDC_SPLIT_DROP_CNT_EN adds an 8-bit
//                saturating count of inputs dropped while busy.
//  Revision    : 1.0 - initial release
// ============================================================================
module tdc_split_x50
    import tdc_pkg::*;
#(
    parameter int IN_W    = C_IN_W,
    parameter int Q_W     = C_Q_W,
    parameter int FRAC_W  = C_FRAC_W,
    parameter int DIVISOR = C_DIVISOR
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [IN_W-1:0]   in_data,
    input  logic              in_dval,
    output logic              busy,
    output logic [Q_W-1:0]    int_out,
    output logic [FRAC_W-1:0] frac_out,
    output logic              out_dval
`ifdef TDC_SPLIT_DROP_CNT_EN
    ,
    output logic [7:0]        drop_cnt
`endif
);

    localparam int                 C_CNT_W    = (IN_W > 1) ? $clog2(IN_W) : 1;
    localparam logic [C_CNT_W-1:0] C_CNT_LOAD = C_CNT_W'(IN_W - 1);

    tdc_state_t         r_state;
    logic [C_CNT_W-1:0] r_cnt;
    logic [FRAC_W:0]    r_rem;
    // Dividend bits shift out of the top while quotient bits shift in at the
    // bottom; after IN_W steps the register holds the full quotient.
    logic [IN_W-1:0]    r_shift;

    logic [FRAC_W:0]    w_rem_next;
    logic               w_q_bit;
    logic [IN_W-1:0]    w_shift_next;

    assign w_shift_next = (r_shift << 1) | IN_W'(w_q_bit);

    tdc_div_step #(
        .FRAC_W  (FRAC_W),
        .DIVISOR (DIVISOR)
    ) u_div_step (
        .i_rem      (r_rem),
        .i_bit      (r_shift[IN_W-1]),
        .o_rem_next (w_rem_next),
        .o_q_bit    (w_q_bit)
    );

    // Controller: accept in IDLE/DONE, step in CALC, publish on CALC exit
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_rem    <= '0;
            r_shift  <= '0;
            busy     <= 1'b0;
            out_dval <= 1'b0;
            int_out  <= '0;
            frac_out <= '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    out_dval <= 1'b0;
                    if (in_dval) begin
                        r_shift <= in_data;
                        r_cnt   <= C_CNT_LOAD;
                        r_rem   <= '0;
                        busy    <= 1'b1;
                        r_state <= ST_CALC;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_CALC: begin
                    r_shift <= w_shift_next;
                    r_rem   <= w_rem_next;
                    if (r_cnt == '0) begin
                        int_out  <= Q_W'(w_shift_next);
                        frac_out <= w_rem_next[FRAC_W-1:0];
                        out_dval <= 1'b1;
                        busy     <= 1'b0;
                        r_state  <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt - C_CNT_W'(1);
                    end
                end
                default: begin
                    busy     <= 1'b0;
                    out_dval <= 1'b0;
                    r_state  <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef TDC_SPLIT_DROP_CNT_EN
    // Count inputs that arrive while a division is running, saturating at 255
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt <= 8'd0;
        end else if (in_dval && (r_state == ST_CALC) && (drop_cnt != 8'hFF)) begin
            drop_cnt <= drop_cnt + 8'd1;
        end
    end
`endif

endmodule : tdc_split_x50
`default_nettype wire

// File: tb/tb_tdc_split_x50.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tdc_split_x50
//  Description : Directed self-checking bench for tdc_split_x50 at default
//                parameters (IN_W=37, Q_W=32, FRAC_W=7, DIVISOR=50).
//                Honours TDC_SPLIT_DROP_CNT_EN when defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tdc_split_x50;

    logic        clk = 1'b0;
    logic        rst;
    logic [36:0] in_data;
    logic        in_dval;
    logic        busy;
    logic [31:0] int_out;
    logic [6:0]  frac_out;
    logic        out_dval;
`ifdef TDC_SPLIT_DROP_CNT_EN
    logic [7:0]  drop_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    tdc_split_x50 dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_dval  (in_dval),
        .busy     (busy),
        .int_out  (int_out),
        .frac_out (frac_out),
        .out_dval (out_dval)
`ifdef TDC_SPLIT_DROP_CNT_EN
        ,
        .drop_cnt (drop_cnt)
`endif
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Present one input for the current cycle (called at a falling edge)
    task automatic send(input logic [36:0] d);
        in_data = d;
        in_dval = 1'b1;
    endtask

    // Drop in_dval, wait for the result and check latency, value and busy
    task automatic wait_result(input string tag, input logic [31:0] eq, input logic [6:0] ef);
        int lat;
        @(negedge clk);
        in_dval = 1'b0;
        lat = 1;
        check({tag, "_busy_calc"}, 64'(busy), 64'd1);
        while (!out_dval && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, 64'(lat), 64'd38);
        check({tag, "_int"},  64'(int_out),  64'(eq));
        check({tag, "_frac"}, 64'(frac_out), 64'(ef));
        check({tag, "_busy_done"}, 64'(busy), 64'd0);
    endtask

    // One cycle after DONE: pulse gone, results held
    task automatic settle(input string tag, input logic [31:0] eq, input logic [6:0] ef);
        @(negedge clk);
        check({tag, "_dval_pulse"}, 64'(out_dval), 64'd0);
        check({tag, "_int_hold"},  64'(int_out),  64'(eq));
        check({tag, "_frac_hold"}, 64'(frac_out), 64'(ef));
    endtask

    initial begin
        int lat;
        int seen;

        // Reset with in_dval held high: input must be ignored
        rst     = 1'b1;
        in_dval = 1'b1;
        in_data = 37'd1234;
        repeat (3) @(negedge clk);
        check("rst_busy",  64'(busy),     64'd0);
        check("rst_dval",  64'(out_dval), 64'd0);
        check("rst_int",   64'(int_out),  64'd0);
        check("rst_frac",  64'(frac_out), 64'd0);
`ifdef TDC_SPLIT_DROP_CNT_EN
        check("rst_drop",  64'(drop_cnt), 64'd0);
`endif
        rst     = 1'b0;
        in_dval = 1'b0;
        @(negedge clk);
        check("idle_busy", 64'(busy), 64'd0);

        // Directed single conversions
        send(37'd0);            wait_result("zero", 32'd0, 7'd0);           settle("zero", 32'd0, 7'd0);
        send(37'd1234);         wait_result("v1234", 32'd24, 7'd34);        settle("v1234", 32'd24, 7'd34);
        send(37'd49);           wait_result("v49", 32'd0, 7'd49);           settle("v49", 32'd0, 7'd49);
        send(37'd50);           wait_result("v50", 32'd1, 7'd0);            settle("v50", 32'd1, 7'd0);
        send(37'd137438953471); wait_result("vmax", 32'd2748779069, 7'd21); settle("vmax", 32'd2748779069, 7'd21);

        // Back-to-back: next input on the out_dval cycle
        send(37'd49);  wait_result("b2b_first", 32'd0, 7'd49);
        send(37'd100); wait_result("b2b", 32'd2, 7'd0);
        settle("b2b", 32'd2, 7'd0);

        // in_dval during CALC (3 cycles, different data) must be ignored
        send(37'd1234);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            in_dval = (lat >= 5 && lat <= 7);
            in_data = 37'd99;
        end while (!out_dval && lat < 100);
        check("drop_latency", 64'(lat),      64'd38);
        check("drop_int",     64'(int_out),  64'd24);
        check("drop_frac",    64'(frac_out), 64'd34);
`ifdef TDC_SPLIT_DROP_CNT_EN
        check("drop_cnt",     64'(drop_cnt), 64'd3);
`endif
        settle("drop", 32'd24, 7'd34);

        // Reset in the 10th CALC cycle abandons the division
        send(37'd123456);
        @(negedge clk);
        in_dval = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_busy", 64'(busy),     64'd0);
        check("midrst_dval", 64'(out_dval), 64'd0);
        check("midrst_int",  64'(int_out),  64'd0);
        check("midrst_frac", 64'(frac_out), 64'd0);
`ifdef TDC_SPLIT_DROP_CNT_EN
        check("midrst_drop", 64'(drop_cnt), 64'd0);
`endif
        seen = 0;
        repeat (45) begin
            @(negedge clk);
            if (out_dval) seen = 1;
        end
        check("midrst_no_dval", 64'(seen), 64'd0);
        send(37'd1234); wait_result("post_rst", 32'd24, 7'd34); settle("post_rst", 32'd24, 7'd34);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_tdc_split_x50
`default_nettype wire

// File: doc/tdc_split_x50.md
TDC_SPLIT_X50 -- requirements
Module: tdc_split_x50

Interface
REQ-001 SHALL have parameter IN_W, default 37, meaning the width of the fine-unit time input.
REQ-002 SHALL have parameter Q_W, default 32, meaning the width of the coarse (integer) output.
REQ-003 SHALL have parameter FRAC_W, default 7, meaning the width of the fine (fractional) output.
REQ-004 SHALL have parameter DIVISOR, default 50, meaning the fine units per coarse tick; legal only if DIVISOR < 2^FRAC_W and (2^IN_W-1)/DIVISOR < 2^Q_W.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port in_data, input, IN_W bits: time value in fine units.
REQ-008 SHALL have port in_dval, input, 1 bit: in_data is valid this cycle.
REQ-009 SHALL have port busy, output, 1 bit: a division is in progress and in_dval is ignored.
REQ-010 SHALL have port int_out, output, Q_W bits: quotient, in_data / DIVISOR.
REQ-011 SHALL have port frac_out, output, FRAC_W bits: remainder, in_data mod DIVISOR, zero-extended.
REQ-012 SHALL have port out_dval, output, 1 bit: single-cycle pulse marking int_out and frac_out valid.

Function
REQ-013 SHALL implement FSM states IDLE, CALC and DONE.
REQ-014 SHALL sample in_data when in_dval=1 and the state is IDLE or DONE, load the bit counter with IN_W-1, clear the partial remainder, and enter CALC.
REQ-015 SHALL perform one restoring-division step per CALC cycle, MSB first: rem = {rem, next dividend bit}; if rem >= DIVISOR then subtract DIVISOR and shift in quotient bit 1, else shift in 0.
REQ-016 SHALL leave CALC for DONE on the step where the counter equals 0, giving exactly IN_W CALC cycles.
REQ-017 SHALL register int_out and frac_out on CALC exit, and hold them until the next CALC exit.
REQ-018 SHALL assert out_dval only during the DONE cycle, IN_W+1 clock edges after the sampling edge (38 at defaults).
REQ-019 SHALL go from DONE to IDLE if in_dval=0, and to CALC if in_dval=1 (back-to-back; throughput one result per IN_W+1 cycles).
REQ-020 SHALL drive busy=1 exactly while in CALC.
REQ-021 SHALL ignore in_dval during CALC without disturbing the division in progress.
REQ-022 SHALL keep the remainder register FRAC_W+1 bits wide so the pre-subtract compare never overflows.

Reset
REQ-023 SHALL on rst=1 force state=IDLE, busy=0, out_dval=0, int_out=0, frac_out=0, counter=0 and remainder=0.
REQ-024 SHALL abandon an in-progress division when rst is asserted mid-CALC, with no out_dval pulse for it.
REQ-025 SHALL ignore in_dval in any cycle where rst=1.

Configuration
REQ-026 SHALL, with TDC_SPLIT_DROP_CNT_EN defined, add output drop_cnt (8 bits), which increments on every in_dval=1 during CALC, saturates at 255 and resets to 0.
REQ-027 SHALL, without TDC_SPLIT_DROP_CNT_EN, have no drop_cnt port and no counter logic.

Structure
REQ-028 SHALL place the state enum, default widths and the default DIVISOR constant in the shared package tdc_pkg.
REQ-029 SHALL use one combinational sub-module, tdc_div_step, that maps (rem, in_bit) to (rem_next, q_bit); the FSM, counter and registers stay in tdc_split_x50.

Verification
REQ-030 SHALL verify that in_data=0 with in_dval for 1 cycle gives int_out=0, frac_out=0, with out_dval 38 cycles later.
REQ-031 SHALL verify that in_data=1234 gives int_out=24, frac_out=34; in_data=49 gives 0/49; in_data=50 gives 1/0.
REQ-032 SHALL verify that in_data=2^37-1 (137438953471) gives int_out=2748779069, frac_out=21.
REQ-033 SHALL verify that in_dval asserted during CALC is ignored: results match the first input, and drop_cnt increments when TDC_SPLIT_DROP_CNT_EN is defined.
REQ-034 SHALL verify back-to-back inputs: in_dval=1 on the out_dval cycle with 100 gives a next result of 2/0 with out_dval 38 cycles later.
REQ-035 SHALL verify that rst pulsed at CALC cycle 10 gives no out_dval, all outputs 0, and a following input of 1234 gives a correct result.
